// File: rtl/td4_core.sv
// TD4 4-bit CPU core: one instruction per CE-qualified edge, PC drives the external ROM.
// Optional macro TD4_HALT_EN: a JMP to its own address halts the core until reset.
module td4_core (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE,
    output logic [3:0] ROM_A,
    input  logic [7:0] ROM_Q,
    input  logic [3:0] IN_PORT,
    output logic [3:0] OUT_PORT,
    output logic       CARRY,
    output logic       HALT
);

    typedef enum logic [3:0] {
        OP_ADD_A = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A  = 4'b0010,
        OP_MOV_A = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B = 4'b0101,
        OP_IN_B  = 4'b0110,
        OP_MOV_B = 4'b0111,
        OP_OUT_B = 4'b1001,
        OP_OUT_I = 4'b1011,
        OP_JNC   = 4'b1110,
        OP_JMP   = 4'b1111
    } opcode_e;

    logic [3:0] pc_q, pc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] out_q, out_d;
    logic       c_q, c_d;
    logic       run;
    logic       jmp_self;

    logic [3:0] opcode;
    logic [3:0] imm;
    logic [4:0] sum_a;
    logic [4:0] sum_b;

    assign opcode = ROM_Q[7:4];
    assign imm    = ROM_Q[3:0];
    assign sum_a  = {1'b0, a_q} + {1'b0, imm};
    assign sum_b  = {1'b0, b_q} + {1'b0, imm};
    assign jmp_self = (opcode == OP_JMP) && (imm == pc_q);

`ifdef TD4_HALT_EN
    logic halted_q, halted_d;

    assign run  = CE && !halted_q;
    assign HALT = halted_q;

    always_comb begin
        halted_d = halted_q;
        if (run && jmp_self) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    // Without halt support a JMP to self just re-executes every edge.
    logic unused_jmp_self;

    assign unused_jmp_self = jmp_self;
    assign run  = CE;
    assign HALT = 1'b0;
`endif

    always_comb begin
        pc_d  = pc_q;
        a_d   = a_q;
        b_d   = b_q;
        out_d = out_q;
        c_d   = c_q;
        if (run) begin
            pc_d = pc_q + 4'd1;
            c_d  = 1'b0;
            case (opcode)
                OP_ADD_A:  {c_d, a_d} = sum_a;
                OP_ADD_B:  {c_d, b_d} = sum_b;
                OP_MOV_A:  a_d = imm;
                OP_MOV_B:  b_d = imm;
                OP_MOV_AB: a_d = b_q;
                OP_MOV_BA: b_d = a_q;
                OP_IN_A:   a_d = IN_PORT;
                OP_IN_B:   b_d = IN_PORT;
                OP_OUT_B:  out_d = b_q;
                OP_OUT_I:  out_d = imm;
                OP_JMP:    pc_d = imm;
                // JNC tests the carry left by the previous instruction.
                OP_JNC:    if (!c_q) pc_d = imm;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_q  <= 4'd0;
            a_q   <= 4'd0;
            b_q   <= 4'd0;
            out_q <= 4'd0;
            c_q   <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            out_q <= out_d;
            c_q   <= c_d;
        end
    end

    assign ROM_A    = pc_q;
    assign OUT_PORT = out_q;
    assign CARRY    = c_q;

endmodule
